// File: rtl/data_ram_pipe.sv
// Byte-lane single-port data RAM for the MEM stage: registered read (1 or 2 cycles),
// accept/ack handshake, post-reset zero fill and misaligned-access detection.
module data_ram_pipe #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   data_i,
    output logic                ready_o,
    output logic                ack_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                err_o
);
    localparam int LANES     = DATA_W / 8;
    localparam int LANE_LOG2 = $clog2(LANES);
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int IDX_LO    = LANE_LOG2;
    localparam int IDX_HI    = DEPTH_LOG2 + LANE_LOG2 - 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DEPTH_LOG2-1:0]   r_cnt;
    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [LANE_LOG2-1:0]    w_lane_off;
    logic                    w_acc;
    logic                    w_err;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_clr;
    logic                    w_unused_addr;

    logic                    r_vld_p0;
    logic                    r_we_p0;
    logic                    r_err_p0;
    logic [DATA_W-1:0]       r_rdata_p0;
    logic                    w_ack_p0;
    logic                    w_err_p0;
    logic [DATA_W-1:0]       w_data_p0;

    // Legal patterns are naturally aligned power-of-two lane groups; multi-lane
    // groups must also start at the lane the byte address points to.
    function automatic logic f_aligned(input logic [LANES-1:0] s,
                                       input logic [LANE_LOG2-1:0] a);
        logic             ok;
        logic [LANES-1:0] pat;
        int               span;
        ok  = 1'b0;
        pat = '0;
        for (int k = 0; k <= LANE_LOG2; k++) begin
            span = 1 << k;
            for (int o = 0; o < LANES; o++) begin
                if (o % span == 0) begin
                    for (int j = 0; j < LANES; j++) begin
                        pat[j] = (j >= o) && (j < o + span);
                    end
                    if (s == pat && (k == 0 || a == o[LANE_LOG2-1:0])) begin
                        ok = 1'b1;
                    end
                end
            end
        end
        return ok;
    endfunction

    assign w_idx         = addr[IDX_HI:IDX_LO];
    assign w_lane_off    = addr[LANE_LOG2-1:0];
    assign w_unused_addr = ^addr;
    assign ready_o       = (r_state == S_RUN);
    assign w_acc         = ce && ready_o && !rst;
    assign w_err         = !f_aligned(sel, w_lane_off);
    assign w_wr          = w_acc && we && !w_err;
    assign w_rd          = w_acc && !we;
    assign w_clr         = (r_state == S_INIT) && (INIT_CLEAR != 0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: begin
                if (INIT_CLEAR == 0 || r_cnt == {DEPTH_LOG2{1'b1}}) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    // Stage p0: accept edge captures the request tag and the pre-write word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_we_p0  <= we;
            r_err_p0 <= w_err;
        end
        if (w_rd) begin
            r_rdata_p0 <= r_mem[w_idx];
        end
    end

    assign w_ack_p0  = r_vld_p0;
    assign w_err_p0  = r_vld_p0 && r_err_p0;
    assign w_data_p0 = (r_vld_p0 && !r_we_p0 && !r_err_p0) ? r_rdata_p0 : '0;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_vld_p1;
            logic              r_err_p1;
            logic [DATA_W-1:0] r_data_p1;

            // Stage p1: optional output register for timing closure
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p1 <= 1'b0;
                end else begin
                    r_vld_p1 <= w_ack_p0;
                end
            end

            always_ff @(posedge clk) begin
                r_err_p1  <= w_err_p0;
                r_data_p1 <= w_data_p0;
            end

            assign ack_o  = r_vld_p1;
            assign err_o  = r_vld_p1 && r_err_p1;
            assign data_o = r_vld_p1 ? r_data_p1 : '0;
        end else begin : g_lat1
            assign ack_o  = w_ack_p0;
            assign err_o  = w_err_p0;
            assign data_o = w_data_p0;
        end
    endgenerate
endmodule

// File: doc/data_ram_pipe.md
Name: data_ram_pipe

Overview:
- Parametrised successor of the data-memory block. Byte-lane-addressed, single-port synchronous RAM for the MEM stage.
- Adds a configurable registered read latency and an accept/ack handshake.
- Adds a post-reset memory-clear state machine and misaligned-access detection.
- Sits between the MEM-stage load/store unit and the on-chip data store. Intended to replace combinational-read data memory in deeper pipelines.

Parameters:
- DATA_W, 32: data word width; must be a multiple of 8. LANES = DATA_W/8, LANE_LOG2 = log2(LANES).
- ADDR_W, 32: byte-address width.
- DEPTH_LOG2, 10: log2 of the number of words. DEPTH = 2**DEPTH_LOG2.
- READ_LAT, 1: cycles from accept to ack. Legal values are 1 and 2.
- INIT_CLEAR, 1: 1 = zero all memory after reset before accepting requests. 0 = skip the clear.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- ce  in  1  request valid
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  byte address
- sel  in  LANES  byte-lane enables; sel[i] maps to data bits [8i+7:8i]
- data_i  in  DATA_W  write data
- ready_o  out  1  block can accept a request this cycle
- ack_o  out  1  one-cycle completion pulse
- data_o  out  DATA_W  read data; valid only while ack_o is high
- err_o  out  1  misaligned-access flag; valid only while ack_o is high

Behaviour:
- Reset: rst is sampled at posedge. On reset, ready_o=0, ack_o=0, data_o=0, err_o=0, and all in-flight pipeline stages are flushed. Reset asserted mid-operation drops pending acks and restarts the FSM in INIT. Memory contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT with INIT_CLEAR=1: a DEPTH_LOG2-bit counter starts at 0 and writes zero to all lanes of word[cnt], one word per cycle. After writing DEPTH-1 the FSM goes to RUN. ready_o=0 throughout INIT, so the clear takes exactly DEPTH cycles.
  - INIT with INIT_CLEAR=0: the FSM leaves INIT on the first cycle after rst deasserts.
  - RUN: ready_o=1 continuously.
- Accept: a request is accepted when ce & ready_o at a posedge. One request may be accepted per cycle, back-to-back, with no bubbles. When ready_o=0, ce is ignored; the requester must hold the request until accepted.
- Word index: addr[DEPTH_LOG2+LANE_LOG2-1 : LANE_LOG2]. Upper address bits are ignored, so addresses alias modulo DEPTH words.
- Alignment check (LANES=4), with a = addr[1:0]:
  - sel=1111 requires a=0.
  - sel=0011 requires a=0; sel=1100 requires a=2.
  - Single-lane sel is always legal.
  - Any other sel pattern, including 0000, is an error.
  - The general rule: sel must be one of the contiguous aligned byte, half-word or word patterns.
- Write: a legal accepted write updates only the selected lanes of the word, at the accepting edge. A write with an error updates nothing.
- Read: the whole word is returned regardless of sel. A read accepted at edge N observes every write accepted at edge N-1 or earlier, so read-after-write with no gap returns the new data.
- Ack timing:
  - Every accepted request, read or write, legal or erroneous, produces exactly one ack_o pulse READ_LAT cycles after acceptance. Acks stay in request order.
  - For a write ack: data_o=0.
  - For an error ack: err_o=1 and data_o=0.
  - With READ_LAT=2, the extra stage registers data_o, err_o and the ack tag.
- Outputs when ack_o=0: data_o=0 and err_o=0.

Test Plan:
- Init clear: DEPTH=1024, INIT_CLEAR=1, rst high for 2 cycles then released -> ready_o low for exactly 1024 cycles; a read of addr 0x3FC afterwards returns 0x00000000.
- Byte write and read: write 0xAABBCCDD to addr 0x10 with sel=1111, then write 0x00001100 to addr 0x10 with sel=0010, then read addr 0x10 -> ack READ_LAT cycles after each request; read data_o=0xAABB11DD.
- Back-to-back traffic, READ_LAT=2: write 0x12345678 to addr 0x20, then on the next cycle read addr 0x20 -> acks on consecutive cycles; read data_o=0x12345678.
- Misaligned access: write to addr 0x22 with sel=1111 and data 0xFFFFFFFF -> ack with err_o=1; a later read of addr 0x20 returns the old word unchanged.
- Reset mid-stream: with READ_LAT=2, accept a read, then assert rst on the next cycle -> no ack_o occurs; ready_o=0 until INIT completes.
- Aliasing: write 0xCAFEF00D to addr 0x1000 (DEPTH_LOG2=10) -> a read of addr 0x0 returns 0xCAFEF00D.
